// File: rtl/ula_seq_if.sv
// rtl/ula_seq_if.sv - request/result bundle for the sequential multiply/divide unit
//
// Purpose: groups the request strobe, operands and result/status signals of ula_seq.
// Ports (master drives request, slave drives result):
//   start  request strobe, sampled only while busy=0
//   op     operation code (3 MLT, 4 DIV, 5 MOD, others unsupported)
//   in1    signed first operand (multiplicand / dividend)
//   in2    signed second operand (multiplier / divisor)
//   busy   high from the cycle after accept through the done cycle
//   done   single-cycle completion pulse
//   out    signed registered result
//   dz     divide-by-zero flag, valid with done
//   err    unsupported-op flag, valid with done
interface ula_seq_if #(
  parameter int NUBITS = 32
);
  logic                     start;
  logic [3:0]               op;
  logic signed [NUBITS-1:0] in1;
  logic signed [NUBITS-1:0] in2;
  logic                     busy;
  logic                     done;
  logic signed [NUBITS-1:0] out;
  logic                     dz;
  logic                     err;

  modport master (
    output start, op, in1, in2,
    input  busy, done, out, dz, err
  );

  modport slave (
    input  start, op, in1, in2,
    output busy, done, out, dz, err
  );
endinterface

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - iterative signed multiply / divide / modulo unit
//
// Purpose: computes in1*in2 (low NUBITS bits), in1/in2 (truncated toward zero) or
// in1%in2 (sign of in1) one bit per cycle on operand magnitudes, then applies the
// result sign in a single fix-up cycle.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   ula_seq_if slave: start/op/in1/in2 in, busy/done/out/dz/err out
module ula_seq #(
  parameter int NUBITS = 32
) (
  input  logic     clk,
  input  logic     rst,
  ula_seq_if.slave bus
);

  localparam logic [3:0] OP_MLT = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_MOD = 4'd5;
  localparam int         CW     = $clog2(NUBITS + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(NUBITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q;
  logic [3:0]        op_q;
  logic              neg_res_q;   // in1/in2 signs differ: product/quotient negative
  logic              neg_rem_q;   // in1 negative: remainder negative
  // acc_q: product accumulator (MLT) or partial remainder (DIV/MOD)
  // q_q:   multiplier shifting right (MLT) or dividend->quotient shifting left
  // b_q:   multiplicand shifting left (MLT) or divisor magnitude
  logic [NUBITS-1:0] acc_q, q_q, b_q;
  logic [NUBITS-1:0] out_q;
  logic              dz_q, err_q;

  // Request decode
  logic              accept;
  logic              op_sup;
  logic              div_zero;
  logic [NUBITS-1:0] mag1, mag2;

  always_comb begin
    accept   = (state_q == IDLE) && bus.start;
    op_sup   = (bus.op == OP_MLT) || (bus.op == OP_DIV) || (bus.op == OP_MOD);
    div_zero = ((bus.op == OP_DIV) || (bus.op == OP_MOD)) && (bus.in2 == '0);
    // The most-negative value maps onto itself, which read unsigned is its magnitude.
    mag1     = bus.in1[NUBITS-1] ? -bus.in1 : bus.in1;
    mag2     = bus.in2[NUBITS-1] ? -bus.in2 : bus.in2;
  end

  // One iteration step of either datapath
  logic [NUBITS:0]   rem_sh;
  logic [NUBITS:0]   trial;
  logic [NUBITS-1:0] acc_d, q_d, b_d;

  always_comb begin
    acc_d  = acc_q;
    q_d    = q_q;
    b_d    = b_q;
    rem_sh = {acc_q, q_q[NUBITS-1]};
    trial  = rem_sh - {1'b0, b_q};
    if (op_q == OP_MLT) begin
      acc_d = acc_q + (q_q[0] ? b_q : '0);
      q_d   = q_q >> 1;
      b_d   = b_q << 1;
    end else if (trial[NUBITS]) begin
      // Trial subtraction went negative: restore the shifted remainder.
      acc_d = rem_sh[NUBITS-1:0];
      q_d   = {q_q[NUBITS-2:0], 1'b0};
    end else begin
      acc_d = trial[NUBITS-1:0];
      q_d   = {q_q[NUBITS-2:0], 1'b1};
    end
  end

  // Sign fix-up of the magnitude result
  logic [NUBITS-1:0] fix_res;

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MLT:  fix_res = neg_res_q ? -acc_q : acc_q;
      OP_DIV:  fix_res = neg_res_q ? -q_q : q_q;
      default: fix_res = neg_rem_q ? -acc_q : acc_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (!op_sup || div_zero) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      q_q       <= '0;
      b_q       <= '0;
      out_q     <= '0;
      dz_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q      <= bus.op;
            neg_res_q <= bus.in1[NUBITS-1] ^ bus.in2[NUBITS-1];
            neg_rem_q <= bus.in1[NUBITS-1];
            cnt_q     <= '0;
            acc_q     <= '0;
            if (bus.op == OP_MLT) begin
              q_q <= mag2;
              b_q <= mag1;
            end else begin
              q_q <= mag1;
              b_q <= mag2;
            end
            // Early completions write their result now; done follows next cycle.
            if (!op_sup) begin
              out_q <= bus.in2;
              err_q <= 1'b1;
              dz_q  <= 1'b0;
            end else if (div_zero) begin
              out_q <= (bus.op == OP_DIV) ? '1 : bus.in1;
              err_q <= 1'b0;
              dz_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          out_q <= fix_res;
          dz_q  <= 1'b0;
          err_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.out  = out_q;
  assign bus.dz   = dz_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - self-checking bench for ula_seq against an arithmetic reference
module tb_ula_seq;
  localparam int N      = 32;
  localparam int PERIOD = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(PERIOD/2) clk = ~clk;

  ula_seq_if #(.NUBITS(N)) bus ();

  ula_seq #(.NUBITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: plain signed arithmetic on 64-bit values.
  function automatic void model(input logic [3:0] op, input logic signed [N-1:0] a,
                                input logic signed [N-1:0] b, output logic [N-1:0] r,
                                output logic dz, output logic err, output int lat);
    longint la, lb, lr;
    la  = a;
    lb  = b;
    lr  = 0;
    dz  = 1'b0;
    err = 1'b0;
    lat = N + 2;
    if (op == 4'd3) begin
      lr = la * lb;
    end else if (op == 4'd4 || op == 4'd5) begin
      if (b == 0) begin
        dz  = 1'b1;
        lat = 1;
        lr  = (op == 4'd4) ? -1 : la;
      end else begin
        lr = (op == 4'd4) ? la / lb : la % lb;
      end
    end else begin
      err = 1'b1;
      lat = 1;
      lr  = lb;
    end
    r = lr[N-1:0];
  endfunction

  // Issues one request from a negedge and returns at the negedge of the done cycle.
  task automatic run_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit hold, output logic [N-1:0] r, output logic dz_o,
                        output logic err_o, output int lat, output int busy_cnt,
                        output longint acc_t);
    int g;
    g = 0;
    while (bus.busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    bus.op  = 4'($urandom);
    bus.in1 = $urandom;
    bus.in2 = $urandom;
    lat      = -1;
    busy_cnt = 0;
    r        = 'x;
    dz_o     = 1'bx;
    err_o    = 1'bx;
    for (int k = 1; k <= 200; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat   = k;
        r     = bus.out;
        dz_o  = bus.dz;
        err_o = bus.err;
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== '0 || bus.dz !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b out=%h dz=%b err=%b, required all zero",
               bus.busy, bus.done, bus.out, bus.dz, bus.err);
    end
  endtask

  task automatic test_directed();
    logic [3:0]   ops [12] = '{4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd3, 4'd4, 4'd5, 4'd2, 4'd4, 4'd5, 4'd15};
    logic [N-1:0] as  [12] = '{32'd100, -32'd100, 32'd100, -32'd100, 32'd12345, 32'h40000000,
                               32'd7, 32'd7, 32'd9, 32'h80000000, 32'h80000000, 32'd1};
    logic [N-1:0] bs  [12] = '{32'd7, 32'd7, -32'd7, 32'd7, -32'd3, 32'd4,
                               32'd0, 32'd0, 32'd55, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hABCD};
    logic [N-1:0] req [12] = '{32'd14, -32'd2, 32'd2, -32'd14, -32'd37035, 32'd0,
                               32'hFFFFFFFF, 32'd7, 32'd55, 32'h80000000, 32'd0, 32'hABCD};
    logic [N-1:0] r, er;
    logic dz, err, edz, eerr;
    int lat, elat, bc;
    longint t;
    for (int i = 0; i < 12; i++) begin
      model(ops[i], as[i], bs[i], er, edz, eerr, elat);
      run_op(ops[i], as[i], bs[i], 1'b0, r, dz, err, lat, bc, t);
      n_checks += 5;
      if (r !== req[i] || r !== er) begin
        n_fail++;
        $display("FAIL directed_out[%0d]: got %h required %h", i, r, req[i]);
      end
      if (lat !== elat) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, elat);
      end
      if (dz !== edz) begin
        n_fail++;
        $display("FAIL directed_dz[%0d]: got %b required %b", i, dz, edz);
      end
      if (err !== eerr) begin
        n_fail++;
        $display("FAIL directed_err[%0d]: got %b required %b", i, err, eerr);
      end
      if (bc !== elat) begin
        n_fail++;
        $display("FAIL directed_busy_cycles[%0d]: got %0d required %0d", i, bc, elat);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [N-1:0] a, b, r, er;
    logic dz, err, edz, eerr;
    int lat, elat, bc;
    longint t;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       op = 4'd3;
        1:       op = 4'd4;
        2:       op = 4'd5;
        default: op = 4'($urandom);
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, N - 1);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) b = '1;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      model(op, a, b, er, edz, eerr, elat);
      run_op(op, a, b, 1'b0, r, dz, err, lat, bc, t);
      n_checks++;
      if (r !== er || dz !== edz || err !== eerr || lat !== elat || bc !== elat) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got out=%h dz=%b err=%b lat=%0d busy=%0d required out=%h dz=%b err=%b lat=%0d",
                 i, op, a, b, r, dz, err, lat, bc, er, edz, eerr, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] r;
    logic dz, err;
    int lat, bc;
    longint t1, t2;
    run_op(4'd3, 32'd1000, 32'd1000, 1'b0, r, dz, err, lat, bc, t1);
    run_op(4'd4, 32'd1000, 32'd8, 1'b0, r, dz, err, lat, bc, t2);
    n_checks += 2;
    if ((t2 - t1) / PERIOD != N + 3) begin
      n_fail++;
      $display("FAIL back_to_back_spacing: got %0d cycles required %0d", (t2 - t1) / PERIOD, N + 3);
    end
    if (r !== 32'd125 || lat !== N + 2) begin
      n_fail++;
      $display("FAIL back_to_back_second: got out=%h lat=%0d required out=%h lat=%0d", r, lat, 32'd125, N + 2);
    end
  endtask

  task automatic test_held_start();
    logic [N-1:0] r;
    logic dz, err;
    int lat, bc, extra;
    longint t;
    run_op(4'd5, 32'd1001, 32'd10, 1'b1, r, dz, err, lat, bc, t);
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    n_checks += 2;
    if (r !== 32'd1 || lat !== N + 2) begin
      n_fail++;
      $display("FAIL held_start_result: got out=%h lat=%0d required out=%h lat=%0d", r, lat, 32'd1, N + 2);
    end
    if (extra !== 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_start_extra_done: got %0d dones busy=%b required 0 dones busy=0", extra, bus.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] r;
    logic dz, err;
    int lat, bc, seen;
    longint t;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd4;
    bus.in1   = 32'd100;
    bus.in2   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out !== '0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op_async: got busy=%b out=%h done=%b required 0/0/0", bus.busy, bus.out, bus.done);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_op_no_done: got %0d dones required 0", seen);
    end
    run_op(4'd4, 32'd100, 32'd7, 1'b0, r, dz, err, lat, bc, t);
    n_checks++;
    if (r !== 32'd14 || lat !== N + 2 || dz !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op_restart: got out=%h lat=%0d dz=%b err=%b required %h %0d 0 0",
               r, lat, dz, err, 32'd14, N + 2);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.in1   = '0;
    bus.in2   = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_random();
    test_back_to_back();
    test_held_start();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(PERIOD * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
